dsc_slice_sched: RTL and testbench
==================================

# dsc_slice_sched

Frame-level slice scheduler for the DSC compression path. It accepts one picture/slice configuration per frame and validates the slice geometry. It then walks the picture in raster slice order and dispatches each slice origin and its chunk size to the first idle of NUM_ENG slice engines. It reports frame completion once every engine has returned done.

## Interface

Parameters:
- NUM_ENG, 2, number of slice engines served (1..8)
- DIM_W, 16, width of picture/slice dimension fields
- BPP_W, 10, width of bits_per_pixel, unsigned with 4 fractional bits (1/16 bpp)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  high only in IDLE; accept = cfg_valid & cfg_ready
- cfg_pic_w, cfg_pic_h  in  DIM_W  picture width/height in pixels
- cfg_slice_w, cfg_slice_h  in  DIM_W  slice width/height in pixels
- cfg_bpp  in  BPP_W  bits_per_pixel, u(BPP_W-4).4
- abort  in  1  cancel current frame
- eng_start  out  NUM_ENG  one-hot, one-cycle start pulse
- eng_x, eng_y  out  DIM_W  slice origin; valid with eng_start
- eng_chunk_size  out  16  bytes per slice line; valid with eng_start
- eng_slice_idx  out  DIM_W  raster slice index; valid with eng_start
- eng_done  in  NUM_ENG  per-engine one-cycle completion pulse
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse when the frame completes
- cfg_err  out  1  one-cycle pulse when a configuration is rejected
- slice_cnt  out  DIM_W  slices dispatched in the current frame

## Operation

- States: IDLE, CHECK, DISPATCH, DRAIN.
- IDLE → CHECK on accept:
  - Latch all cfg fields.
  - Set rw=pic_w, rh=pic_h.
  - Clear slice_cnt, x, y and eng_busy mask.
- CHECK, first cycle:
  - If slice_w==0, slice_h==0, pic_w==0, pic_h==0 or bpp==0: pulse cfg_err, go to IDLE.
  - Otherwise compute chunk = (slice_w*bpp + 127) >> 7 at full width (DIM_W+BPP_W bits).
  - If chunk > 65535: pulse cfg_err, go to IDLE.
- CHECK, each cycle:
  - If rw >= slice_w, then rw -= slice_w.
  - If rh >= slice_h, then rh -= slice_h.
  - Once rw < slice_w and rh < slice_h: if rw!=0 or rh!=0, pulse cfg_err and go to IDLE; else go to DISPATCH.
- DISPATCH, each cycle:
  - Idle set = ~eng_busy, using the registered mask.
  - If the idle set is non-empty, pick the lowest-index idle engine.
  - Pulse its eng_start bit and drive x, y, chunk, slice_cnt as the index.
  - Set its busy bit and increment slice_cnt.
  - Advance x += slice_w. If the new x == pic_w: x=0, y += slice_h.
  - After dispatching the slice with y+slice_h == pic_h and x+slice_w == pic_w, go to DRAIN.
- eng_done[i] clears eng_busy[i] at the clock edge.
  - An engine freed this cycle becomes eligible the following cycle.
  - A done from a non-busy engine is ignored.
  - A done simultaneous with the start of the same engine cannot occur because that engine is busy.
- DRAIN: when eng_busy==0, pulse frame_done and go to IDLE.
- abort, any non-IDLE state:
  - Next state is IDLE and eng_busy is cleared.
  - No frame_done and no cfg_err.
  - Late eng_done pulses are ignored.
  - abort takes priority over all other transitions, including frame completion in the same cycle.
- cfg_valid outside IDLE is ignored (cfg_ready=0).

## Timing

- Reset values:
  - State IDLE.
  - cfg_ready=1, busy=0, eng_start=0, eng_x=eng_y=eng_slice_idx=0, eng_chunk_size=0.
  - frame_done=0, cfg_err=0, slice_cnt=0.
- All outputs are registered. cfg_ready is decoded from the state register.
- Accept at cycle T:
  - CHECK occupies T+1 .. T+1+max(pic_w/slice_w, pic_h/slice_h).
  - The first eng_start follows in the next cycle.
- cfg_err is asserted in the cycle after the failing CHECK evaluation. IDLE (cfg_ready=1) follows in the same cycle.
- At most one eng_start bit is set per cycle.
- With all engines idle, one slice is issued per cycle.
- frame_done is asserted in the cycle after the last busy bit clears. cfg_ready=1 in that same cycle, so back-to-back frames are possible.
- abort at cycle T: cfg_ready=1 and all outputs are quiescent at T+1.

## Test plan

- pic 64x32, slice 16x8, bpp 128 (8.0), NUM_ENG=2, engines done 3 cycles after start:
  - Exactly 16 starts in raster order (x 0,16,32,48 per row; y 0,8,16,24).
  - chunk=16 on every start.
  - Engines alternate 0/1 when done arrives on time.
  - One frame_done; slice_cnt=16.
- Chunk rounding: slice_w=30, bpp=152 (9.5) → eng_chunk_size=36. slice_w=16, bpp=128 → 16.
- Geometry errors:
  - pic_w=50, slice_w=16 → cfg_err pulse, no eng_start.
  - slice_h=0 → cfg_err on the first CHECK cycle.
  - Both return to cfg_ready=1.
- Engine stall: engine 0 never returns done. Remaining slices all go to engine 1, one per done. DRAIN holds with busy=1 until engine 0 done, then frame_done.
- abort mid-DISPATCH after 5 starts:
  - Next cycle IDLE, no frame_done.
  - A later eng_done is ignored.
  - A new config is accepted and restarts from x=y=0, slice_cnt=0.
- Reset asserted mid-frame: all outputs are at reset values asynchronously; no eng_start after deassertion until a new accept.

Source files
------------

// File: rtl/dsc_slice_sched.sv
// Frame-level DSC slice scheduler: validates slice geometry, then hands slice
// origins in raster order to the lowest-index idle engine and waits for all done.
module dsc_slice_sched #(
  parameter int NUM_ENG = 2,
  parameter int DIM_W   = 16,
  parameter int BPP_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DIM_W-1:0]   cfg_pic_w,
  input  logic [DIM_W-1:0]   cfg_pic_h,
  input  logic [DIM_W-1:0]   cfg_slice_w,
  input  logic [DIM_W-1:0]   cfg_slice_h,
  input  logic [BPP_W-1:0]   cfg_bpp,
  input  logic               abort,
  output logic [NUM_ENG-1:0] eng_start,
  output logic [DIM_W-1:0]   eng_x,
  output logic [DIM_W-1:0]   eng_y,
  output logic [15:0]        eng_chunk_size,
  output logic [DIM_W-1:0]   eng_slice_idx,
  input  logic [NUM_ENG-1:0] eng_done,
  output logic               busy,
  output logic               frame_done,
  output logic               cfg_err,
  output logic [DIM_W-1:0]   slice_cnt,
  output logic [1:0]         state_dbg
);

  // cfg handshake: a configuration is taken on a rising edge where
  // cfg_valid & cfg_ready; cfg_ready is high exactly while the FSM is IDLE.

  localparam int PROD_W = DIM_W + BPP_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CHECK    = 2'd1,
    S_DISPATCH = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0]   pic_w_q, pic_h_q, slice_w_q, slice_h_q;
  logic [BPP_W-1:0]   bpp_q;
  logic [DIM_W-1:0]   rw_q, rh_q;
  logic [DIM_W-1:0]   x_q, y_q;
  logic [15:0]        chunk_q;
  logic               check_first_q;
  logic [NUM_ENG-1:0] eng_busy_q;

  logic               accept;
  logic [PROD_W-1:0]  prod;
  logic [PROD_W-1:0]  chunk_full;
  logic               cfg_zero, chunk_big;
  logic               geom_done, geom_bad;
  logic               has_idle;
  logic [NUM_ENG-1:0] pick_oh;
  logic [DIM_W:0]     x_sum, y_sum;
  logic               row_end, last_slice;

  logic err_set, done_set, dispatch;

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;
  assign accept    = cfg_valid & cfg_ready;

  // Chunk size in bytes: slice_w * bpp carries 4 fractional bits, so /16 for
  // bits and /8 for bytes, rounded up.
  assign prod       = PROD_W'(slice_w_q) * PROD_W'(bpp_q);
  assign chunk_full = (prod + PROD_W'(127)) >> 7;
  assign chunk_big  = (chunk_full > PROD_W'(65535));
  assign cfg_zero   = (slice_w_q == '0) || (slice_h_q == '0) || (pic_w_q == '0) ||
                      (pic_h_q == '0) || (bpp_q == '0);

  assign geom_done = (rw_q < slice_w_q) && (rh_q < slice_h_q);
  assign geom_bad  = (rw_q != '0) || (rh_q != '0);

  assign x_sum      = {1'b0, x_q} + {1'b0, slice_w_q};
  assign y_sum      = {1'b0, y_q} + {1'b0, slice_h_q};
  assign row_end    = (x_sum == {1'b0, pic_w_q});
  assign last_slice = row_end && (y_sum == {1'b0, pic_h_q});

  always_comb begin
    pick_oh  = '0;
    has_idle = 1'b0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (!eng_busy_q[i] && !has_idle) begin
        pick_oh[i] = 1'b1;
        has_idle   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    err_set  = 1'b0;
    done_set = 1'b0;
    dispatch = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (check_first_q && (cfg_zero || chunk_big)) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end else if (geom_done) begin
          if (geom_bad) begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DISPATCH;
          end
        end
      end
      S_DISPATCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (has_idle) begin
          dispatch = 1'b1;
          if (last_slice) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (eng_busy_q == '0) begin
          done_set = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pic_w_q        <= '0;
      pic_h_q        <= '0;
      slice_w_q      <= '0;
      slice_h_q      <= '0;
      bpp_q          <= '0;
      rw_q           <= '0;
      rh_q           <= '0;
      x_q            <= '0;
      y_q            <= '0;
      chunk_q        <= '0;
      check_first_q  <= 1'b0;
      eng_busy_q     <= '0;
      eng_start      <= '0;
      eng_x          <= '0;
      eng_y          <= '0;
      eng_chunk_size <= '0;
      eng_slice_idx  <= '0;
      frame_done     <= 1'b0;
      cfg_err        <= 1'b0;
      slice_cnt      <= '0;
    end else begin
      eng_start  <= '0;
      frame_done <= done_set;
      cfg_err    <= err_set;

      if (accept) begin
        pic_w_q       <= cfg_pic_w;
        pic_h_q       <= cfg_pic_h;
        slice_w_q     <= cfg_slice_w;
        slice_h_q     <= cfg_slice_h;
        bpp_q         <= cfg_bpp;
        rw_q          <= cfg_pic_w;
        rh_q          <= cfg_pic_h;
        x_q           <= '0;
        y_q           <= '0;
        slice_cnt     <= '0;
        check_first_q <= 1'b1;
      end

      // Geometry check divides by repeated subtraction, one step per cycle.
      if (state_q == S_CHECK) begin
        check_first_q <= 1'b0;
        if (check_first_q) chunk_q <= chunk_full[15:0];
        if (rw_q >= slice_w_q) rw_q <= rw_q - slice_w_q;
        if (rh_q >= slice_h_q) rh_q <= rh_q - slice_h_q;
      end

      // Done pulses outside an active frame (or after abort) must not leak in.
      if (abort || state_q == S_IDLE) begin
        eng_busy_q <= '0;
      end else begin
        eng_busy_q <= (eng_busy_q & ~eng_done) | (dispatch ? pick_oh : '0);
      end

      if (dispatch) begin
        eng_start      <= pick_oh;
        eng_x          <= x_q;
        eng_y          <= y_q;
        eng_chunk_size <= chunk_q;
        eng_slice_idx  <= slice_cnt;
        slice_cnt      <= slice_cnt + DIM_W'(1);
        if (row_end) begin
          x_q <= '0;
          y_q <= y_sum[DIM_W-1:0];
        end else begin
          x_q <= x_sum[DIM_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_dsc_slice_sched.sv
// Directed bench for dsc_slice_sched: expected slice dispatches are queued by
// the stimulus side and popped by an independent monitor on every eng_start.
module tb_dsc_slice_sched;

  localparam int NUM_ENG = 2;
  localparam int DIM_W   = 16;
  localparam int BPP_W   = 10;
  localparam int ENG_LAT = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [DIM_W-1:0]   cfg_pic_w, cfg_pic_h, cfg_slice_w, cfg_slice_h;
  logic [BPP_W-1:0]   cfg_bpp;
  logic               abort;
  logic [NUM_ENG-1:0] eng_start;
  logic [DIM_W-1:0]   eng_x, eng_y, eng_slice_idx;
  logic [15:0]        eng_chunk_size;
  logic [NUM_ENG-1:0] eng_done;
  logic               busy, frame_done, cfg_err;
  logic [DIM_W-1:0]   slice_cnt;
  logic [1:0]         state_dbg;

  dsc_slice_sched #(.NUM_ENG(NUM_ENG), .DIM_W(DIM_W), .BPP_W(BPP_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pic_w(cfg_pic_w), .cfg_pic_h(cfg_pic_h),
    .cfg_slice_w(cfg_slice_w), .cfg_slice_h(cfg_slice_h), .cfg_bpp(cfg_bpp),
    .abort(abort),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_chunk_size(eng_chunk_size), .eng_slice_idx(eng_slice_idx),
    .eng_done(eng_done),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err),
    .slice_cnt(slice_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;
  int err_cnt  = 0;

  // {engine one-hot[8], x, y, chunk, slice_idx}
  logic [71:0] exp_q[$];

  logic [NUM_ENG-1:0] stall    = '0;
  logic [NUM_ENG-1:0] man_done = '0;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cfg_valid = 1'b0;
    abort     = 1'b0;
    cfg_pic_w = '0; cfg_pic_h = '0; cfg_slice_w = '0; cfg_slice_h = '0; cfg_bpp = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- engine model ----------------
  initial begin
    int timer[NUM_ENG];
    for (int i = 0; i < NUM_ENG; i++) timer[i] = 0;
    eng_done = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_ENG; i++) begin
        eng_done[i] = man_done[i];
        if (timer[i] > 0) begin
          timer[i]--;
          if (timer[i] == 0 && !stall[i]) eng_done[i] = 1'b1;
        end
        if (eng_start[i]) timer[i] = ENG_LAT;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [71:0] got, exp;
    forever begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (cfg_err) err_cnt++;
      if (eng_start != '0) begin
        got = {8'(eng_start), eng_x, eng_y, eng_chunk_size, eng_slice_idx};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start got=%0h exp=none", got);
        end else begin
          exp = exp_q.pop_front();
          check("dispatch", got, exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cfg(input int pw, input int ph, input int sw, input int sh, input int bpp);
    int n = 0;
    while (!cfg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    cfg_pic_w   = DIM_W'(pw);
    cfg_pic_h   = DIM_W'(ph);
    cfg_slice_w = DIM_W'(sw);
    cfg_slice_h = DIM_W'(sh);
    cfg_bpp     = BPP_W'(bpp);
    cfg_valid   = 1'b1;
    @(negedge clk);
    cfg_valid   = 1'b0;
  endtask

  // mode 0: engines alternate; mode 1: engine 0 takes slice 0, engine 1 the rest
  task automatic push_frame(input int pw, input int ph, input int sw, input int sh,
                            input int chunk, input int mode, input int limit);
    int idx = 0;
    int e;
    for (int y = 0; y < ph; y += sh) begin
      for (int x = 0; x < pw; x += sw) begin
        if (idx < limit) begin
          e = (mode == 0) ? (idx % 2) : ((idx == 0) ? 0 : 1);
          exp_q.push_back({8'(1 << e), 16'(x), 16'(y), 16'(chunk), 16'(idx)});
        end
        idx++;
      end
    end
  endtask

  task automatic wait_fd(input string name, input int target);
    int n = 0;
    while (fd_cnt < target && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(name, 72'(fd_cnt), 72'(target));
  endtask

  task automatic wait_err(input string name, input int target);
    int n = 0;
    while (err_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 72'(err_cnt), 72'(target));
  endtask

  task automatic pulse_done(input int e);
    man_done[e] = 1'b1;
    @(negedge clk);
    man_done[e] = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    do_reset();
    check("rst_cfg_ready",  72'(cfg_ready), 72'(1));
    check("rst_busy",       72'(busy), 72'(0));
    check("rst_eng_start",  72'(eng_start), 72'(0));
    check("rst_eng_xy",     72'({eng_x, eng_y, eng_slice_idx}), 72'(0));
    check("rst_chunk",      72'(eng_chunk_size), 72'(0));
    check("rst_pulses",     72'({frame_done, cfg_err}), 72'(0));
    check("rst_slice_cnt",  72'(slice_cnt), 72'(0));

    // Full frame 64x32 / 16x8 at 8.0 bpp: 16 slices, chunk 16
    push_frame(64, 32, 16, 8, 16, 0, 100);
    send_cfg(64, 32, 16, 8, 128);
    wait_fd("main_frame_done", 1);
    check("main_slice_cnt", 72'(slice_cnt), 72'(16));
    check("main_queue_empty", 72'(exp_q.size()), 72'(0));
    check("main_no_err", 72'(err_cnt), 72'(0));
    check("main_idle", 72'({cfg_ready, busy}), 72'(2'b10));

    // Chunk rounding: 30 px at 9.5 bpp -> 36 bytes
    push_frame(60, 8, 30, 8, 36, 0, 100);
    send_cfg(60, 8, 30, 8, 152);
    wait_fd("round_frame_done", 2);
    // Minimum bpp rounds up to one byte; single-slice frame
    push_frame(10, 4, 10, 4, 1, 0, 100);
    send_cfg(10, 4, 10, 4, 1);
    wait_fd("tiny_frame_done", 3);
    check("tiny_slice_cnt", 72'(slice_cnt), 72'(1));

    // Geometry error: 50 not a multiple of 16
    send_cfg(50, 32, 16, 8, 128);
    wait_err("geom_err", 1);
    @(negedge clk);
    check("geom_err_idle", 72'({cfg_ready, busy}), 72'(2'b10));

    // slice_h == 0: error right after the first CHECK cycle
    send_cfg(64, 32, 16, 0, 128);
    @(negedge clk);
    check("zero_sh_err_pulse", 72'({cfg_err, cfg_ready}), 72'(2'b11));
    wait_err("zero_sh_err", 2);

    // bpp == 0 and chunk overflow (16000 px * 63.9375 bpp)
    send_cfg(64, 32, 16, 8, 0);
    wait_err("zero_bpp_err", 3);
    send_cfg(16000, 1, 16000, 1, 1023);
    wait_err("chunk_ovf_err", 4);
    check("err_no_frame_done", 72'(fd_cnt), 72'(3));

    // Engine stall: engine 0 never returns done on its own
    stall = 2'b01;
    push_frame(64, 8, 16, 8, 16, 1, 100);
    send_cfg(64, 8, 16, 8, 128);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check("stall_drain_busy", 72'({busy, cfg_ready}), 72'(2'b10));
    check("stall_no_frame_done", 72'(fd_cnt), 72'(3));
    check("stall_queue_empty", 72'(exp_q.size()), 72'(0));
    pulse_done(0);
    wait_fd("stall_frame_done", 4);
    stall = 2'b00;

    // Abort after 5 starts, then a fresh frame
    push_frame(64, 32, 16, 8, 16, 0, 5);
    send_cfg(64, 32, 16, 8, 128);
    n = 0;
    while (n < 5) begin
      if (eng_start != '0) n++;
      if (n < 5) @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 72'({cfg_ready, busy, eng_start}), 72'({1'b1, 1'b0, 2'b00}));
    pulse_done(1);
    repeat (10) @(negedge clk);
    check("abort_no_frame_done", 72'(fd_cnt), 72'(4));
    check("abort_no_err", 72'(err_cnt), 72'(4));
    check("abort_slice_cnt", 72'(slice_cnt), 72'(5));
    push_frame(32, 8, 16, 8, 16, 0, 100);
    send_cfg(32, 8, 16, 8, 128);
    wait_fd("post_abort_frame_done", 5);
    check("post_abort_slice_cnt", 72'(slice_cnt), 72'(2));

    // Asynchronous reset mid-frame
    push_frame(64, 32, 16, 8, 16, 0, 100);
    send_cfg(64, 32, 16, 8, 128);
    n = 0;
    while (n < 3) begin
      @(negedge clk);
      if (eng_start != '0) n++;
    end
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", 72'({cfg_ready, busy, eng_start}), 72'({1'b1, 1'b0, 2'b00}));
    check("async_rst_cnt", 72'({slice_cnt, eng_x, eng_y}), 72'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("post_rst_idle", 72'({cfg_ready, busy}), 72'(2'b10));
    check("final_queue_empty", 72'(exp_q.size()), 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
